knight_cmd_sequencer: RTL

//  Sequences the RemoteComm command link to the KnightsTour robot. Commands are queued locally,

---
 rtl/knight_cmd_pkg.sv | 33 +++
 rtl/knight_cmd_sequencer_cmd_fifo.sv | 51 +++++
 rtl/knight_cmd_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/knight_cmd_pkg.sv
// Shared constants and types for the KnightsTour command sequencer.
package knight_cmd_pkg;

  localparam int unsigned CMD_W   = 16;
  localparam int unsigned TIMER_W = 27;
  localparam int unsigned NACK_W  = 6;

  localparam logic [15:0] CAL_GYRO = 16'h2000;
  localparam logic [3:0]  MOVE     = 4'h4;
  localparam logic [3:0]  TOUR     = 4'h6;
  localparam logic [7:0]  POS_ACK  = 8'hA5;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_SNT, WAIT_RESP, DONE, ERR} seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_NAK     = 2'b01,
    ERR_RESP_TO = 2'b10,
    ERR_SNT_TO  = 2'b11
  } err_code_t;

  // Command word as carried on the RemoteComm link
  typedef struct packed {
    logic [3:0]  opcode;
    logic [11:0] operand;
  } cmd_word_t;

  // Build a command word from opcode and operand
  function automatic logic [15:0] mk_cmd(input logic [3:0] op, input logic [11:0] operand);
    return {op, operand};
  endfunction

endpackage

// File: rtl/knight_cmd_sequencer_cmd_fifo.sv
// Circular command queue with wrap-bit pointers; push when full is dropped.
module cmd_fifo
  import knight_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  cmd_word_t din,
  output cmd_word_t dout,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  cmd_word_t      mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush returns both pointers to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/knight_cmd_sequencer.sv
// Queues commands and issues them to RemoteComm one at a time, waiting for each ACK.
module knight_cmd_sequencer
  import knight_cmd_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter bit          FAST_SIM = 1'b1,
  parameter int unsigned TO_FAST  = 2**20,
  parameter int unsigned TO_FULL  = 2**26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [CMD_W-1:0]  push_cmd,
  input  logic              start,
  input  logic              abort,
  output logic              full,
  output logic              empty,
  output logic [CMD_W-1:0]  cmd,
  output logic              snd_cmd,
  input  logic              cmd_snt,
  input  logic              resp_rdy,
  input  logic [7:0]        resp,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [NACK_W-1:0] n_acked
);

  localparam logic [TIMER_W-1:0] LIMIT = FAST_SIM ? TIMER_W'(TO_FAST) : TIMER_W'(TO_FULL);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_SEND      = 3'd2;
  localparam logic [2:0] ST_WAIT_SNT  = 3'd3;
  localparam logic [2:0] ST_WAIT_RESP = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;
  localparam logic [2:0] ST_ERR       = 3'd6;

  logic [2:0]         state, state_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [CMD_W-1:0]   cmd_nxt;
  logic               snd_nxt, busy_nxt, done_nxt, err_nxt;
  logic [1:0]         code_nxt;
  logic [NACK_W-1:0]  nack_nxt;
  logic               pop_c, flush_c;
  cmd_word_t          head;

  cmd_fifo #(.DEPTH(DEPTH)) iFIFO (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop_c),
    .flush (flush_c),
    .din   (push_cmd),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // State, timer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      timer    <= '0;
      cmd      <= '0;
      snd_cmd  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      n_acked  <= '0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      cmd      <= cmd_nxt;
      snd_cmd  <= snd_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      err_code <= code_nxt;
      n_acked  <= nack_nxt;
    end
  end

  // Next-state, timer and status decode; abort overrides every other event
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    cmd_nxt   = cmd;
    done_nxt  = done;
    err_nxt   = err;
    code_nxt  = err_code;
    nack_nxt  = n_acked;
    pop_c     = 1'b0;
    flush_c   = 1'b0;

    if (abort) begin
      state_nxt = ST_IDLE;
      timer_nxt = '0;
      flush_c   = 1'b1;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      code_nxt  = ERR_NONE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            err_nxt   = 1'b0;
            code_nxt  = ERR_NONE;
            nack_nxt  = '0;
            done_nxt  = empty;
            state_nxt = empty ? ST_DONE : ST_LOAD;
          end
        end
        ST_LOAD: begin
          pop_c     = 1'b1;
          cmd_nxt   = head;
          state_nxt = ST_SEND;
        end
        ST_SEND: begin
          timer_nxt = '0;
          state_nxt = ST_WAIT_SNT;
        end
        ST_WAIT_SNT: begin
          if (cmd_snt) begin
            timer_nxt = '0;
            state_nxt = ST_WAIT_RESP;
          end else if (timer == LIMIT) begin
            err_nxt   = 1'b1;
            code_nxt  = ERR_SNT_TO;
            state_nxt = ST_ERR;
          end else begin
            timer_nxt = timer + TIMER_W'(1);
          end
        end
        ST_WAIT_RESP: begin
          if (resp_rdy) begin
            if (resp == POS_ACK) begin
              nack_nxt  = (n_acked == '1) ? n_acked : n_acked + NACK_W'(1);
              done_nxt  = empty;
              state_nxt = empty ? ST_DONE : ST_LOAD;
            end else begin
              err_nxt   = 1'b1;
              code_nxt  = ERR_NAK;
              state_nxt = ST_ERR;
            end
          end else if (timer == LIMIT) begin
            err_nxt   = 1'b1;
            code_nxt  = ERR_RESP_TO;
            state_nxt = ST_ERR;
          end else begin
            timer_nxt = timer + TIMER_W'(1);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    snd_nxt  = (state_nxt == ST_SEND);
    busy_nxt = (state_nxt == ST_LOAD) || (state_nxt == ST_SEND) ||
               (state_nxt == ST_WAIT_SNT) || (state_nxt == ST_WAIT_RESP);
  end

endmodule
